// File: rtl/sort_pkg.sv
// Shared types for the 12-input sorting network and its consumers.
//   data_t        : one sorted word
//   vec_t         : SORT_N words, word i at bits [i*32 +: 32] (same packing as in_data)
//   drain_state_t : state of the serial drain engine
package sort_pkg;

  localparam int SORT_N = 12;

  typedef logic [31:0] data_t;
  typedef data_t [SORT_N-1:0] vec_t;

  localparam int SORT_W = $bits(data_t);

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } drain_state_t;

endpackage

// File: rtl/sort_order_check.sv
// Combinational ascending-order checker for one packed vector.
//   data      : N words, word i at bits [i*W +: W]
//   is_sorted : 1 when word i <= word i+1 (unsigned) for every i = 0..N-2
module sort_order_check
  import sort_pkg::*;
#(
  parameter int N = SORT_N,
  parameter int W = SORT_W
) (
  input  logic [N*W-1:0] data,
  output logic           is_sorted
);

  logic [N-2:0] pair_ok;

  for (genvar i = 0; i < N - 1; i++) begin : g_pair
    assign pair_ok[i] = data[i*W +: W] <= data[(i+1)*W +: W];
  end

  assign is_sorted = &pair_ok;

endmodule

// File: rtl/sort_12_drain.sv
// Consumer end of the 12-input sorting network.
// Accepts one parallel sorted vector per handshake into a two-entry buffer and
// streams each vector out one word per beat, ascending or descending.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : parallel vector handshake
//   in_data             : N*W packed vector, word 0 expected smallest
//   in_desc             : sampled on accept, 1 = emit words N-1..0
//   out_valid/out_ready : serial word handshake
//   out_data/out_idx    : current word and its beat number within the vector
//   out_last            : high on beat N-1
//   order_err, clr_err  : sticky unsorted-vector flag and its synchronous clear
//   vec_count           : completed vectors, wraps at 16 bits
module sort_12_drain
  import sort_pkg::*;
#(
  parameter int N = SORT_N,
  parameter int W = SORT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_desc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [3:0]     out_idx,
  output logic           out_last,
  output logic           order_err,
  input  logic           clr_err,
  output logic [15:0]    vec_count
);

  drain_state_t   state_q, state_d;
  logic [N*W-1:0] ent_q [2];
  logic [1:0]     desc_q;
  logic           wr_ptr, rd_ptr;
  logic [1:0]     occ_q, occ_d;
  logic [3:0]     beat_q;
  logic [3:0]     word_sel;
  logic           rdy_q;
  logic           accept, fire, last_fire;
  logic           is_sorted;

  sort_order_check #(.N(N), .W(W)) u_check (
    .data      (in_data),
    .is_sorted (is_sorted)
  );

  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = rdy_q && (occ_q < 2'd2);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign last_fire = fire && out_last;

  // Occupancy after this edge; accept and final beat together cancel out.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned, which would infer a latch.
    occ_d = occ_q;
    case ({accept, last_fire})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. A final beat with another vector waiting stays in STREAM,
  // so consecutive vectors flow without a bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (occ_d != 2'd0) state_d = ST_STREAM;
      ST_STREAM: if (last_fire && occ_d == 2'd0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs, from registers and muxes only.
  always_comb begin
    word_sel  = desc_q[rd_ptr] ? 4'(N - 1) - beat_q : beat_q;
    out_valid = (state_q == ST_STREAM);
    out_idx   = beat_q;
    out_last  = (beat_q == 4'(N - 1));
    out_data  = ent_q[rd_ptr][word_sel*W +: W];
  end

  // Datapath: buffers, pointers, beat counter, flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      // NOTE: the vector buffers are reset so out_data reads zero out of reset and no stale vector survives.
      ent_q[0]  <= '0;
      ent_q[1]  <= '0;
      desc_q    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ_q     <= '0;
      beat_q    <= '0;
      order_err <= 1'b0;
      vec_count <= '0;
    end else begin
      rdy_q <= 1'b1;
      occ_q <= occ_d;

      if (accept) begin
        ent_q[wr_ptr]  <= in_data;
        desc_q[wr_ptr] <= in_desc;
        wr_ptr         <= ~wr_ptr;
      end

      if (fire) begin
        if (out_last) begin
          beat_q    <= '0;
          rd_ptr    <= ~rd_ptr;
          vec_count <= vec_count + 16'd1;
        end else begin
          beat_q <= beat_q + 4'd1;
        end
      end

      // A violation in the same cycle as clr_err keeps the flag set.
      if (accept && !is_sorted) order_err <= 1'b1;
      else if (clr_err)         order_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sort_12_drain.sv
// Self-checking bench for sort_12_drain: directed scenarios followed by a
// randomized phase, with a scoreboard queue of expected beats checked by an
// independent monitor at every falling edge.
module tb_sort_12_drain;
  import sort_pkg::*;

  localparam int N = SORT_N;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   idx;
    logic         last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] in_data = '0;
  logic           in_desc = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [3:0]     out_idx;
  logic           out_last;
  logic           order_err;
  logic           clr_err = 1'b0;
  logic [15:0]    vec_count;

  sort_12_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_desc   (in_desc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .order_err (order_err),
    .clr_err   (clr_err),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_fire_cyc = -1;
  bit          rel = 1'b0;
  beat_t       exp_q[$];
  logic [15:0] exp_vc = '0;
  logic        exp_err = 1'b0;
  bit          stop_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // A clock edge has been seen since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rel <= 1'b0;
    else        rel <= 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Sorted means equal to its own sorted copy.
  function automatic bit model_sorted(input logic [N*W-1:0] v);
    logic [W-1:0] orig[$];
    logic [W-1:0] srt[$];
    for (int i = 0; i < N; i++) orig.push_back(v[i*W +: W]);
    srt = orig;
    srt.sort();
    for (int i = 0; i < N; i++) if (srt[i] != orig[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [N*W-1:0] ramp(input logic [W-1:0] base);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = base + W'(10 * (i + 1));
    return v;
  endfunction

  // Monitor / scoreboard.
  int    mon_vecs;
  beat_t mon_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_vc  = '0;
      exp_err = 1'b0;
    end else begin
      mon_vecs = (exp_q.size() + N - 1) / N;
      check("out_valid", out_valid, exp_q.size() != 0);
      check("vec_count", vec_count, exp_vc);
      check("order_err", order_err, exp_err);
      if (rel) check("in_ready", in_ready, mon_vecs < 2);
      else     check("in_ready_release", in_ready, 0);

      if (out_valid && exp_q.size() != 0) begin
        mon_b = exp_q[0];
        check("out_data", out_data, mon_b.data);
        check("out_idx", out_idx, mon_b.idx);
        check("out_last", out_last, mon_b.last);
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (mon_b.last) begin
            exp_vc++;
            last_fire_cyc = cyc;
          end
        end
      end

      if (in_valid && in_ready) begin
        for (int b = 0; b < N; b++) begin
          int    w;
          beat_t e;
          w = in_desc ? N - 1 - b : b;
          e.data = in_data[w*W +: W];
          e.idx  = 4'(b);
          e.last = (b == N - 1);
          exp_q.push_back(e);
        end
        if (!model_sorted(in_data)) exp_err = 1'b1;
        else if (clr_err)           exp_err = 1'b0;
      end else if (clr_err) begin
        exp_err = 1'b0;
      end
    end
  end

  // Offers a vector until accepted; returns at posedge+1 after the accept edge.
  task automatic send(input logic [N*W-1:0] v, input logic d, output int acc);
    in_data  = v;
    in_desc  = d;
    in_valid = 1'b1;
    acc      = -1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        break;
      end
    end
    check("send_accepted", acc >= 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!out_valid && exp_q.size() == 0) break;
    end
    check("drain_idle", {out_valid, exp_q.size() != 0}, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int t;
    for (t = 0; t < 60; t++) begin
      if (out_valid && out_idx == idx) break;
      @(posedge clk); #1;
    end
    check("reach_beat", out_idx, idx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int             acc, acc3;
    logic [N*W-1:0] v;
    logic [W-1:0]   w[N];

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_order_err", order_err, 0);
    check("rst_vec_count", vec_count, 0);
    rst_n = 1'b1;
    check("release_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("first_edge_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // 1: single ascending vector, beat 0 the cycle after accept.
    send(ramp(0), 1'b0, acc);
    check("t1_latency_valid", out_valid, 1);
    check("t1_first_data", out_data, 10);
    check("t1_first_idx", out_idx, 0);
    wait_idle();
    check("t1_vec_count", vec_count, 1);
    check("t1_order_err", order_err, 0);

    // 2: descending.
    send(ramp(0), 1'b1, acc);
    check("t2_first_data", out_data, 120);
    check("t2_first_idx", out_idx, 0);
    wait_idle();
    check("t2_vec_count", vec_count, 2);

    // 3: three vectors back to back.
    send(ramp(100), 1'b0, acc);
    send(ramp(200), 1'b1, acc);
    check("t3_ready_drop", in_ready, 0);
    send(ramp(300), 1'b0, acc3);
    check("t3_third_accept_cycle", acc3, last_fire_cyc + 1);
    wait_idle();
    check("t3_vec_count", vec_count, 5);

    // 4: backpressure at beat 4.
    send(ramp(0), 1'b0, acc);
    wait_idx(4'd4);
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("t4_hold_data", out_data, 50);
      check("t4_hold_idx", out_idx, 4);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_resume_data", out_data, 60);
    check("t4_resume_idx", out_idx, 5);
    wait_idle();

    // 5: order error, clear, and set-wins.
    v = ramp(0);
    v[3*W +: W] = 32'hFFFF_FFFF;
    v[4*W +: W] = 32'h0000_0001;
    send(v, 1'b0, acc);
    check("t5_err_set", order_err, 1);
    wait_idle();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("t5_err_clear", order_err, 0);
    clr_err = 1'b1;
    send(v, 1'b0, acc);
    clr_err = 1'b0;
    check("t5_set_wins", order_err, 1);
    wait_idle();

    // 6: reset mid-stream at beat 6.
    send(ramp(0), 1'b0, acc);
    wait_idx(4'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_idx", out_idx, 0);
    check("t6_async_in_ready", in_ready, 0);
    check("t6_async_vec_count", vec_count, 0);
    check("t6_async_order_err", order_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6_release_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("t6_edge_in_ready", in_ready, 1);
    check("t6_vec_count", vec_count, 0);
    send(ramp(500), 1'b1, acc);
    check("t6_restart_idx", out_idx, 0);
    check("t6_restart_data", out_data, 500 + 120);
    wait_idle();

    // Randomized phase.
    fork
      while (!stop_rand) begin
        @(posedge clk); #1;
        if (stop_rand) break;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      while (!stop_rand) begin
        @(posedge clk); #1;
        if (stop_rand) break;
        clr_err = ($urandom_range(0, 15) == 0);
      end
    join_none

    for (int k = 0; k < 150; k++) begin
      for (int i = 0; i < N; i++) w[i] = $urandom;
      if ($urandom_range(0, 7) != 0) w.sort();
      for (int i = 0; i < N; i++) v[i*W +: W] = w[i];
      send(v, 1'($urandom_range(0, 1)), acc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    stop_rand = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
